qoi_enc_stream: RTL



---
 rtl/qoi_enc_stream.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/qoi_enc_stream.sv
// ---------------------------------------------------------------------------
// qoi_enc_stream -- streaming QOI encoder core.
//
// Accepts one pixel per px_valid/px_ready handshake and emits the QOI byte
// stream on an out_valid/out_ready byte interface. Each accepted pixel is
// encoded in one cycle into a small byte buffer (up to 6 bytes: an optional
// pending run byte followed by the pixel's own op), which is then drained one
// byte per accepted handshake. A pending run is flushed on the last pixel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid (and its data) until that edge; the
// consumer may toggle ready freely. out_data/out_last are held stable while
// out_valid && !out_ready.
//
// Optional build macro: QOI_ENC_END_MARKER_EN -- when defined, each frame ends
// with the 8-byte QOI end marker (00 x7, 01) and out_last marks the 01 byte.
//
// Parameters: CHANNELS (3 or 4; 3 forces alpha to 8'hFF), SIZE_W (pixel count
//             width), MAX_RUN (1..62, longest run per QOI_OP_RUN byte).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, num_px   frame start pulse and pixel count (sampled on start)
//   px_valid/px_ready/px_data   pixel stream in (r=[7:0] g b a=[31:24])
//   out_valid/out_ready/out_data/out_last   encoded byte stream out
//   busy, done, px_count        frame status
//   o_dbg_state     current FSM state encoding
// ---------------------------------------------------------------------------
module qoi_enc_stream #(
   parameter int CHANNELS = 4,
   parameter int SIZE_W   = 30,
   parameter int MAX_RUN  = 62
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SIZE_W-1:0] num_px,
   input  logic              px_valid,
   output logic              px_ready,
   input  logic [31:0]       px_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [SIZE_W-1:0] px_count,
   output logic [2:0]        o_dbg_state
);

`ifdef QOI_ENC_END_MARKER_EN
   localparam bit END_MARKER = 1'b1;
`else
   localparam bit END_MARKER = 1'b0;
`endif

   localparam logic [31:0] PREV_INIT = 32'hFF00_0000;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ENCODE, S_EMIT, S_FLUSH, S_FIN
   } state_t;

   state_t            r_state, w_next;
   logic [SIZE_W-1:0] r_num_px, r_px_count;
   logic [31:0]       r_px, r_prev;
   logic [31:0]       r_index [64];
   logic [5:0]        r_run;
   logic              r_is_last;
   logic [7:0]        r_buf [8];
   logic [2:0]        r_len, r_pos;

   logic              w_same, w_idx_hit, w_idx_wr, w_buf_end, w_flush_end;
   logic [5:0]        w_hash, w_run_inc, w_run_nxt;
   logic signed [7:0] w_dr, w_dg, w_db;
   logic signed [8:0] w_dr_dg, w_db_dg;
   logic [7:0]        w_op [5];
   logic [2:0]        w_op_len;
   logic [7:0]        w_buf [8];
   logic [2:0]        w_len;

   // ---------------- encode datapath ----------------
   assign w_same    = (r_px == r_prev);
   assign w_run_inc = r_run + 6'd1;
   // Only the low 6 bits of the weighted sum matter, so 8-bit wrap is harmless.
   assign w_hash    = 6'(r_px[7:0] * 8'd3 + r_px[15:8] * 8'd5 +
                         r_px[23:16] * 8'd7 + r_px[31:24] * 8'd11);
   assign w_idx_hit = (r_index[w_hash] == r_px);
   assign w_dr      = r_px[7:0]   - r_prev[7:0];
   assign w_dg      = r_px[15:8]  - r_prev[15:8];
   assign w_db      = r_px[23:16] - r_prev[23:16];
   // Luma deltas are taken on sign-extended values so they cannot wrap back
   // into range.
   assign w_dr_dg   = {w_dr[7], w_dr} - {w_dg[7], w_dg};
   assign w_db_dg   = {w_db[7], w_db} - {w_dg[7], w_dg};

   always_comb begin
      for (int i = 0; i < 5; i++) w_op[i] = 8'h00;
      for (int i = 0; i < 8; i++) w_buf[i] = 8'h00;
      w_op_len  = 3'd0;
      w_len     = 3'd0;
      w_idx_wr  = 1'b0;
      w_run_nxt = r_run;
      if (w_same) begin
         if (w_run_inc == 6'(MAX_RUN) || r_is_last) begin
            w_buf[0]  = {2'b11, w_run_inc - 6'd1};
            w_len     = 3'd1;
            w_run_nxt = 6'd0;
         end else begin
            w_run_nxt = w_run_inc;
         end
      end else begin
         w_run_nxt = 6'd0;
         if (w_idx_hit) begin
            w_op[0]  = {2'b00, w_hash};
            w_op_len = 3'd1;
         end else begin
            w_idx_wr = 1'b1;
            if (r_px[31:24] != r_prev[31:24]) begin
               w_op[0] = 8'hFF;         w_op[1] = r_px[7:0];
               w_op[2] = r_px[15:8];    w_op[3] = r_px[23:16];
               w_op[4] = r_px[31:24];   w_op_len = 3'd5;
            end else if (w_dr >= -8'sd2 && w_dr <= 8'sd1 &&
                         w_dg >= -8'sd2 && w_dg <= 8'sd1 &&
                         w_db >= -8'sd2 && w_db <= 8'sd1) begin
               w_op[0]  = {2'b01, 2'(w_dr[1:0] + 2'd2), 2'(w_dg[1:0] + 2'd2),
                           2'(w_db[1:0] + 2'd2)};
               w_op_len = 3'd1;
            end else if (w_dg >= -8'sd32 && w_dg <= 8'sd31 &&
                         w_dr_dg >= -9'sd8 && w_dr_dg <= 9'sd7 &&
                         w_db_dg >= -9'sd8 && w_db_dg <= 9'sd7) begin
               w_op[0]  = {2'b10, 6'(w_dg[5:0] + 6'd32)};
               w_op[1]  = {4'(w_dr_dg[3:0] + 4'd8), 4'(w_db_dg[3:0] + 4'd8)};
               w_op_len = 3'd2;
            end else begin
               w_op[0] = 8'hFE;         w_op[1] = r_px[7:0];
               w_op[2] = r_px[15:8];    w_op[3] = r_px[23:16];
               w_op_len = 3'd4;
            end
         end
         // A run interrupted by a different pixel goes out ahead of its op.
         if (r_run != 6'd0) begin
            w_buf[0] = {2'b11, r_run - 6'd1};
            for (int i = 0; i < 5; i++) w_buf[i+1] = w_op[i];
            w_len = w_op_len + 3'd1;
         end else begin
            for (int i = 0; i < 5; i++) w_buf[i] = w_op[i];
            w_len = w_op_len;
         end
      end
   end

   // ---------------- FSM ----------------
   assign w_buf_end   = (r_pos == r_len - 3'd1);
   assign w_flush_end = (r_pos == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      px_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_px != '0)   w_next = S_FETCH;
               else if (END_MARKER) w_next = S_FLUSH;
               else                w_next = S_FIN;
            end
         end
         S_FETCH: begin
            px_ready = 1'b1;
            if (px_valid) w_next = S_ENCODE;
         end
         S_ENCODE: begin
            w_next = (w_len != 3'd0) ? S_EMIT : S_FETCH;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            out_data  = r_buf[r_pos];
            out_last  = r_is_last && w_buf_end && !END_MARKER;
            if (out_ready && w_buf_end) begin
               if (!r_is_last)      w_next = S_FETCH;
               else if (END_MARKER) w_next = S_FLUSH;
               else                 w_next = S_FIN;
            end
         end
         S_FLUSH: begin
            out_valid = 1'b1;
            out_data  = {7'd0, w_flush_end};
            out_last  = w_flush_end;
            if (out_ready && w_flush_end) w_next = S_FIN;
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_px   <= '0;
         r_px_count <= '0;
         r_px       <= '0;
         r_prev     <= PREV_INIT;
         r_run      <= 6'd0;
         r_is_last  <= 1'b0;
         r_len      <= 3'd0;
         r_pos      <= 3'd0;
         for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_num_px   <= num_px;
               r_px_count <= '0;
               r_prev     <= PREV_INIT;
               r_run      <= 6'd0;
               r_is_last  <= 1'b0;
            end
            S_FETCH: if (px_valid) begin
               r_px       <= (CHANNELS == 3) ? {8'hFF, px_data[23:0]} : px_data;
               r_px_count <= r_px_count + SIZE_W'(1);
               r_is_last  <= ((r_px_count + SIZE_W'(1)) == r_num_px);
            end
            S_ENCODE: begin
               r_prev <= r_px;
               r_run  <= w_run_nxt;
               r_buf  <= w_buf;
               r_len  <= w_len;
               r_pos  <= 3'd0;
            end
            S_EMIT:  if (out_ready) r_pos <= w_buf_end ? 3'd0 : r_pos + 3'd1;
            S_FLUSH: if (out_ready) r_pos <= r_pos + 3'd1;   // wraps to 0 after the 01 byte
            default: ;
         endcase
      end
   end

   // Colour index: cleared on reset and at every frame start.
   always_ff @(posedge clk) begin
      if (rst || (r_state == S_IDLE && start)) begin
         for (int i = 0; i < 64; i++) r_index[i] <= 32'h0;
      end else if (r_state == S_ENCODE && w_idx_wr) begin
         r_index[w_hash] <= r_px;
      end
   end

   assign busy        = (r_state == S_FETCH) || (r_state == S_ENCODE) ||
                        (r_state == S_EMIT)  || (r_state == S_FLUSH);
   assign done        = (r_state == S_FIN);
   assign px_count    = r_px_count;
   assign o_dbg_state = r_state;

endmodule
